clock_set_controller: RTL and testbench
=======================================

CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 Parameter DEBOUNCE_SAMPLES, default 3, meaning: consecutive identical 50 Hz samples needed to accept a button level change (legal 2..15).
REQ-002 Parameter REPEAT_DELAY, default 5, meaning: 5 Hz edges with inc held before auto-repeat starts (legal 1..15).
REQ-003 Parameter TIMEOUT_S, default 30, meaning: 1 Hz edges without a press before a set state returns to RUN (legal 2..63).
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 ena_1hz  input  1  1 Hz square wave from the divider.
REQ-007 ena_5hz  input  1  5 Hz square wave from the divider.
REQ-008 ena_50hz  input  1  50 Hz square wave from the divider.
REQ-009 btn_mode  input  1  raw mode button, active-high, asynchronous.
REQ-010 btn_inc  input  1  raw increment button, active-high, asynchronous.
REQ-011 state  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC.
REQ-012 run_tick  output  1  one-cycle pulse: advance time by one second.
REQ-013 inc_hour  output  1  one-cycle pulse: increment hours.
REQ-014 inc_min  output  1  one-cycle pulse: increment minutes.
REQ-015 clr_sec  output  1  one-cycle pulse: clear seconds to 00.
REQ-016 blink  output  1  1 = selected field digits visible, 0 = blanked.

Function
REQ-017 Each ena_* input SHALL feed a registered rising-edge detector producing a one-cycle pulse (e1, e5, e50) the cycle after a registered 0->1 transition.
REQ-018 btn_mode and btn_inc SHALL each pass a 2-flop synchronizer before any use.
REQ-019 Debouncer per button: sample synchronized level on each e50; debounced level SHALL change only after DEBOUNCE_SAMPLES consecutive samples differ from it; counter restarts on any matching sample.
REQ-020 mode_press / inc_press SHALL be one-cycle pulses on debounced 0->1 transitions.
REQ-021 FSM on mode_press: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
REQ-022 In SET states a timeout counter SHALL count e1 pulses; cleared on mode_press, inc_press, debounced inc high, or state change; reaching TIMEOUT_S SHALL force RUN next cycle.
REQ-023 run_tick SHALL pulse on each e1 while state is RUN only; e1 in SET states is not buffered.
REQ-024 SET_HOUR: inc_press SHALL pulse inc_hour; SET_MIN: inc_press SHALL pulse inc_min; SET_SEC: inc_press SHALL pulse clr_sec.
REQ-025 Auto-repeat (SET_HOUR, SET_MIN only): while debounced inc is high, count e5; once count reaches REPEAT_DELAY, each further e5 SHALL emit one extra inc pulse for the current field; count clears when debounced inc goes low or state changes.
REQ-026 In RUN, inc_press and auto-repeat SHALL be ignored.
REQ-027 mode_press and inc_press in the same cycle: mode wins, no inc/clr pulse that cycle.
REQ-028 At most one of run_tick, inc_hour, inc_min, clr_sec SHALL be high in any cycle.
REQ-029 blink SHALL be 1 in RUN; in SET states blink SHALL equal registered ena_1hz level, forced 1 while debounced inc is high.
REQ-030 All outputs SHALL be registered; pulse latency from triggering internal event is exactly one cycle.

Reset
REQ-031 On rst_n low: state=RUN, run_tick=inc_hour=inc_min=clr_sec=0, blink=1; edge-detect history, synchronizers, debounced levels, and all counters SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL abort any set state and repeat sequence immediately; no pulse SHALL appear in the first cycle after release.
REQ-033 A button held through reset release SHALL register as one press after DEBOUNCE_SAMPLES e50 edges.

Verification
REQ-034 RUN, 3 rising edges of ena_1hz -> exactly 3 single-cycle run_tick pulses, one cycle after each registered edge.
REQ-035 btn_mode glitch of 2 e50 samples then 3 clean presses -> no change from glitch, state 01, 10, 11 in turn; 4th press -> 00.
REQ-036 SET_MIN, btn_inc held for 12 e5 edges -> 1 inc_min on press plus 12-5=7 repeat pulses (8 total); blink=1 throughout hold.
REQ-037 SET_HOUR, no buttons for 30 e1 edges -> state 00 next cycle; no inc_hour pulses.
REQ-038 SET_SEC, btn_inc held 10 e5 edges -> exactly one clr_sec pulse.
REQ-039 rst_n low during SET_MIN auto-repeat -> outputs at REQ-031 values asynchronously; after release, state 00 and no pulse until new stimulus.

Source files
------------

// File: rtl/clock_set_controller.sv
// ---------------------------------------------------------------------------
// clock_set_controller
//   Front-panel controller for a clock: turns the two raw buttons and the
//   divider's square waves into one-cycle time-update commands and a blink
//   enable for the field being edited.
//
// Ports
//   clk        system clock (50 MHz)
//   rst_n      asynchronous active-low reset
//   ena_1hz    1 Hz square wave   (edge -> e1)
//   ena_5hz    5 Hz square wave   (edge -> e5, auto-repeat cadence)
//   ena_50hz   50 Hz square wave  (edge -> e50, debounce sample strobe)
//   btn_mode   raw mode button, active-high, asynchronous
//   btn_inc    raw increment button, active-high, asynchronous
//   state      00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   run_tick   one-cycle pulse: advance time by one second
//   inc_hour   one-cycle pulse: increment hours
//   inc_min    one-cycle pulse: increment minutes
//   clr_sec    one-cycle pulse: clear seconds
//   blink      1 = selected field visible, 0 = blanked
// ---------------------------------------------------------------------------
module clock_set_controller #(
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int REPEAT_DELAY     = 5,
    parameter int TIMEOUT_S        = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_1hz,
    input  logic       ena_5hz,
    input  logic       ena_50hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] state,
    output logic       run_tick,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SAMPLES - 1);
    localparam logic [3:0] RD      = 4'(REPEAT_DELAY);
    localparam logic [5:0] TO_MAX  = 6'(TIMEOUT_S);

    // ---------------- enable edge detectors ({50Hz, 5Hz, 1Hz}) ---------------
    logic [2:0] ena_q, ena_qq, ena_rise;
    logic       e1, e5, e50;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q  <= '0;
            ena_qq <= '0;
        end else begin
            ena_q  <= {ena_50hz, ena_5hz, ena_1hz};
            ena_qq <= ena_q;
        end
    end

    assign ena_rise = ena_q & ~ena_qq;
    assign e1       = ena_rise[0];
    assign e5       = ena_rise[1];
    assign e50      = ena_rise[2];

    // ---------------- button sync + debounce ({inc, mode}) -------------------
    logic [1:0]      btn_s1, btn_s2, btn_db, btn_db_q, press;
    logic [1:0][3:0] db_cnt;
    logic            mode_press, inc_press, inc_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_db   <= '0;
            btn_db_q <= '0;
            db_cnt   <= '0;
        end else begin
            btn_s1   <= {btn_inc, btn_mode};
            btn_s2   <= btn_s1;
            btn_db_q <= btn_db;
            if (e50) begin
                for (int b = 0; b < 2; b++) begin
                    // Any sample that agrees with the accepted level restarts
                    // the run; only an unbroken run of disagreeing samples flips it.
                    if (btn_s2[b] == btn_db[b]) begin
                        db_cnt[b] <= '0;
                    end else if (db_cnt[b] == DB_LAST) begin
                        btn_db[b] <= ~btn_db[b];
                        db_cnt[b] <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 4'd1;
                    end
                end
            end
        end
    end

    assign press      = btn_db & ~btn_db_q;
    assign mode_press = press[0];
    assign inc_press  = press[1];
    assign inc_db     = btn_db[1];

    // ---------------- timeout and auto-repeat counters -----------------------
    state_t     state_q, state_nxt;
    logic [5:0] to_cnt;
    logic [3:0] rep_cnt;
    logic       timeout, rep_en, rep_fire;

    assign timeout = (state_q != RUN) && (to_cnt == TO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state_q == RUN || mode_press || inc_press || inc_db || timeout) begin
            // Any user activity or state change restarts the idle window.
            to_cnt <= '0;
        end else if (e1) begin
            to_cnt <= to_cnt + 6'd1;
        end
    end

    assign rep_en   = (state_q == SET_HOUR || state_q == SET_MIN) && inc_db && !mode_press;
    assign rep_fire = rep_en && e5 && (rep_cnt == RD);

    // Counter saturates at the delay; every later e5 is a repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (!rep_en) begin
            rep_cnt <= '0;
        end else if (e5 && rep_cnt != RD) begin
            rep_cnt <= rep_cnt + 4'd1;
        end
    end

    // ---------------- FSM: state register ------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_nxt;
    end

    // ---------------- FSM: next state ----------------------------------------
    always_comb begin
        state_nxt = state_q;
        if (mode_press)   state_nxt = state_t'(state_q + 2'd1);
        else if (timeout) state_nxt = RUN;
    end

    // ---------------- FSM: outputs (registered below) ------------------------
    logic inc_hit;
    logic run_tick_nxt, inc_hour_nxt, inc_min_nxt, clr_sec_nxt, blink_nxt;

    always_comb begin
        // A simultaneous mode press swallows the increment.
        inc_hit      = inc_press && !mode_press;
        run_tick_nxt = e1 && (state_q == RUN);
        inc_hour_nxt = (state_q == SET_HOUR) && (inc_hit || rep_fire);
        inc_min_nxt  = (state_q == SET_MIN)  && (inc_hit || rep_fire);
        clr_sec_nxt  = (state_q == SET_SEC)  && inc_hit;
        // Keep the field lit while the user is holding inc so the value is readable.
        blink_nxt    = (state_q == RUN) || inc_db || ena_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_tick <= 1'b0;
            inc_hour <= 1'b0;
            inc_min  <= 1'b0;
            clr_sec  <= 1'b0;
            blink    <= 1'b1;
        end else begin
            run_tick <= run_tick_nxt;
            inc_hour <= inc_hour_nxt;
            inc_min  <= inc_min_nxt;
            clr_sec  <= clr_sec_nxt;
            blink    <= blink_nxt;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_clock_set_controller.sv
module tb_clock_set_controller;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int TO = 30;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       ena_1hz = 1'b0, ena_5hz = 1'b0, ena_50hz = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0;
    logic [1:0] state;
    logic       run_tick, inc_hour, inc_min, clr_sec, blink;

    clock_set_controller #(
        .DEBOUNCE_SAMPLES(DB), .REPEAT_DELAY(RD), .TIMEOUT_S(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ena_1hz(ena_1hz), .ena_5hz(ena_5hz), .ena_50hz(ena_50hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .state(state), .run_tick(run_tick), .inc_hour(inc_hour),
        .inc_min(inc_min), .clr_sec(clr_sec), .blink(blink)
    );

    always #10 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    int n_run = 0, n_hour = 0, n_min = 0, n_clr = 0, n_multi = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            n_run  += int'(run_tick);
            n_hour += int'(inc_hour);
            n_min  += int'(inc_min);
            n_clr  += int'(clr_sec);
            if (int'(run_tick) + int'(inc_hour) + int'(inc_min) + int'(clr_sec) > 1) n_multi++;
        end
    end

    int total = 0, passed = 0, failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // w: 0 = 1 Hz, 1 = 5 Hz, 2 = 50 Hz
    task automatic pulse_ena(input int w);
        if (w == 0) ena_1hz = 1'b1; else if (w == 1) ena_5hz = 1'b1; else ena_50hz = 1'b1;
        cyc(4);
        if (w == 0) ena_1hz = 1'b0; else if (w == 1) ena_5hz = 1'b0; else ena_50hz = 1'b0;
        cyc(4);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; cyc(4); repeat (DB) pulse_ena(2);
        btn_mode = 1'b0; cyc(4); repeat (DB) pulse_ena(2);
    endtask

    // Hold inc across k 5 Hz edges (all inside the debounced-high window)
    task automatic hold_inc(input int k);
        btn_inc = 1'b1; cyc(4); repeat (DB) pulse_ena(2);
        repeat (k) pulse_ena(1);
        btn_inc = 1'b0; cyc(4); repeat (DB) pulse_ena(2);
    endtask

    // Reference: number of field pulses from holding inc across k 5 Hz edges
    function automatic int hold_pulses(input int st, input int k);
        if (st == 0) return 0;
        if (st == 3) return 1;
        return 1 + ((k > RD) ? k - RD : 0);
    endfunction

    int s_run, s_hour, s_min, s_clr;
    int m_state, m_to, e_run, e_hour, e_min, e_clr, k;

    initial begin
        // ---- reset values
        cyc(3);
        check("rst_state", state, 0);
        check("rst_blink", blink, 1);
        check("rst_run_tick", run_tick, 0);
        check("rst_inc_hour", inc_hour, 0);
        check("rst_inc_min", inc_min, 0);
        check("rst_clr_sec", clr_sec, 0);
        rst_n = 1'b1;
        cyc(2);

        // ---- run ticks: latency and count
        s_run = n_run;
        ena_1hz = 1'b1;
        @(negedge clk); check("tick_lat_early", run_tick, 0);
        @(negedge clk); check("tick_lat_hit", run_tick, 1);
        @(negedge clk); check("tick_lat_after", run_tick, 0);
        ena_1hz = 1'b0; cyc(4);
        check("run_blink", blink, 1);
        pulse_ena(0); pulse_ena(0);
        check("run_tick_count", n_run - s_run, 3);

        // ---- mode glitch then clean presses
        btn_mode = 1'b1; cyc(4); repeat (DB - 1) pulse_ena(2);
        btn_mode = 1'b0; cyc(4); repeat (DB) pulse_ena(2);
        check("glitch_ignored", state, 0);
        press_mode(); check("mode_1", state, 1);
        press_mode(); check("mode_2", state, 2);
        press_mode(); check("mode_3", state, 3);
        press_mode(); check("mode_wrap", state, 0);

        // ---- SET_MIN auto-repeat over 12 e5 edges
        press_mode(); press_mode();
        check("at_set_min", state, 2);
        s_min = n_min;
        btn_inc = 1'b1; cyc(4); repeat (DB) pulse_ena(2);
        check("inc_min_press", n_min - s_min, 1);
        for (int i = 0; i < 12; i++) begin
            pulse_ena(1);
            check("hold_blink", blink, 1);
        end
        btn_inc = 1'b0; cyc(4); repeat (DB) pulse_ena(2);
        check("inc_min_repeat_total", n_min - s_min, hold_pulses(2, 12));

        // ---- SET_HOUR timeout
        press_mode(); press_mode(); press_mode();
        check("at_set_hour", state, 1);
        s_hour = n_hour; s_run = n_run;
        ena_1hz = 1'b1; cyc(3); check("set_blink_on", blink, 1);
        ena_1hz = 1'b0; cyc(3); check("set_blink_off", blink, 0);
        cyc(2);
        repeat (TO - 2) pulse_ena(0);
        check("timeout_early", state, 1);
        pulse_ena(0);
        check("timeout_run", state, 0);
        check("timeout_no_inc", n_hour - s_hour, 0);
        check("timeout_no_tick", n_run - s_run, 0);

        // ---- SET_SEC: held inc clears once
        press_mode(); press_mode(); press_mode();
        check("at_set_sec", state, 3);
        s_clr = n_clr; s_hour = n_hour; s_min = n_min;
        hold_inc(10);
        check("clr_sec_once", n_clr - s_clr, 1);
        check("clr_no_other", (n_hour - s_hour) + (n_min - s_min), 0);

        // ---- mode and inc in the same cycle: mode wins
        press_mode(); press_mode();
        check("at_set_hour2", state, 1);
        s_hour = n_hour; s_min = n_min;
        btn_mode = 1'b1; btn_inc = 1'b1; cyc(4); repeat (DB) pulse_ena(2);
        check("both_state", state, 2);
        check("both_no_inc", (n_hour - s_hour) + (n_min - s_min), 0);
        btn_mode = 1'b0; btn_inc = 1'b0; cyc(4); repeat (DB) pulse_ena(2);

        // ---- reset during SET_MIN auto-repeat
        btn_inc = 1'b1; cyc(4); repeat (DB) pulse_ena(2);
        repeat (RD + 1) pulse_ena(1);
        ena_5hz = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("pre_rst_repeat", inc_min, 1);
        rst_n = 1'b0; #1;
        check("arst_state", state, 0);
        check("arst_inc_min", inc_min, 0);
        check("arst_blink", blink, 1);
        check("arst_others", {29'd0, run_tick, inc_hour, clr_sec}, 0);
        ena_5hz = 1'b0; btn_inc = 1'b0; btn_mode = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        s_run = n_run; s_hour = n_hour; s_min = n_min; s_clr = n_clr;
        cyc(6);
        check("post_rst_quiet", (n_run - s_run) + (n_hour - s_hour) + (n_min - s_min) + (n_clr - s_clr), 0);
        check("post_rst_state", state, 0);
        // mode held through release becomes exactly one press
        repeat (DB - 1) pulse_ena(2);
        check("held_mode_early", state, 0);
        pulse_ena(2);
        check("held_mode_press", state, 1);
        btn_mode = 1'b0; cyc(4); repeat (DB) pulse_ena(2);

        // ---- randomized actions against an action-level model
        m_state = 1; m_to = 0;
        e_run = n_run; e_hour = n_hour; e_min = n_min; e_clr = n_clr;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    press_mode();
                    m_state = (m_state + 1) % 4; m_to = 0;
                end
                1, 2: begin
                    k = $urandom_range(1, 4);
                    repeat (k) begin
                        pulse_ena(0);
                        if (m_state == 0) e_run++;
                        else begin
                            m_to++;
                            if (m_to == TO) begin m_state = 0; m_to = 0; end
                        end
                    end
                end
                default: begin
                    k = $urandom_range(0, 9);
                    hold_inc(k);
                    if (m_state == 1) e_hour += hold_pulses(1, k);
                    if (m_state == 2) e_min  += hold_pulses(2, k);
                    if (m_state == 3) e_clr  += hold_pulses(3, k);
                    if (m_state != 0) m_to = 0;
                end
            endcase
            check("rnd_state", state, m_state);
            check("rnd_run_tick", n_run, e_run);
            check("rnd_inc_hour", n_hour, e_hour);
            check("rnd_inc_min", n_min, e_min);
            check("rnd_clr_sec", n_clr, e_clr);
        end

        check("pulse_exclusive", n_multi, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
